spu_controller: RTL and testbench
=================================

# spu_controller

Control unit for the single-purpose processor (SPU). It fetches 16-bit instructions from instruction memory, decodes them, and drives every control input of `spu_datapath`: register-file addresses and enables, write-back mux select, ALU select, the 8-bit immediate, and data-memory address and strobes. It consumes `rf_rp_zero` from the datapath to resolve conditional jumps, and it owns the program counter (PC) and instruction register (IR).

## Interface
Parameters:
- `PC_W`, 16, program-counter and instruction-address width
- `D_AW`, 8, data-memory address width (equal to the instruction's 8-bit field)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_addr`  out  PC_W  instruction address (equals PC)
- `i_rd`  out  1  instruction read strobe
- `i_data`  in  16  instruction word; combinational read of `i_addr`
- `d_addr`  out  D_AW  data-memory address
- `d_rd`  out  1  data-memory read strobe
- `d_wr`  out  1  data-memory write strobe
- `rf_s1`, `rf_s0`  out  1 each  write-back mux select: 00 ALU, 01 dm_r_data, 10 rf_w_data
- `rf_w_addr`  out  4  register-file write address
- `rf_w_wr`  out  1  register-file write enable
- `rf_rp_addr`  out  4  register-file p-port read address
- `rf_rp_rd`  out  1  p-port read enable
- `rf_rq_addr`  out  4  register-file q-port read address
- `rf_rq_rd`  out  1  q-port read enable
- `rf_w_data`  out  8  immediate for MOVI
- `alu_s1`, `alu_s0`  out  1 each  ALU select: 00 pass p, 01 p+q, 10 p−q
- `rf_rp_zero`  in  1  p-port read data equals zero

## Operation
- Instruction word fields: `op`=IR[15:12], `ra`=IR[11:8], `rb`=IR[7:4], `rc`=IR[3:0], `imm8`=IR[7:0].
- Opcodes:
  - 0 LOAD: RF[ra]=D[imm8]
  - 1 STORE: D[imm8]=RF[ra]
  - 2 ADD: RF[ra]=RF[rb]+RF[rc]
  - 3 MOVI: RF[ra]=imm8
  - 4 SUB: RF[ra]=RF[rb]−RF[rc]
  - 5 JMPZ: if RF[ra]==0, PC=PC_of_JMPZ+sext(imm8)
  - 6–15: no-op; the next state is FETCH.
- FSM states: FETCH, DECODE, LOAD, STORE, ADD, MOVI, SUB, JMPZ, JMPZ_JUMP.
  - FETCH: `i_rd`=1; IR<=i_data; PC<=PC+1; next state DECODE.
  - DECODE: no strobes; next state selected by `op`.
  - LOAD: d_addr=imm8, d_rd=1, rf_w_addr=ra, rf_s=01, rf_w_wr=1.
  - STORE: d_addr=imm8, d_wr=1, rf_rp_addr=ra, rf_rp_rd=1.
  - ADD: rf_rp_addr=rb, rf_rq_addr=rc, both read enables=1, alu_s=01, rf_s=00, rf_w_addr=ra, rf_w_wr=1.
  - SUB: same as ADD except alu_s=10.
  - MOVI: rf_w_data=imm8, rf_s=10, rf_w_addr=ra, rf_w_wr=1.
  - JMPZ: rf_rp_addr=ra, rf_rp_rd=1; next state is JMPZ_JUMP if `rf_rp_zero`=1, otherwise FETCH.
  - JMPZ_JUMP: PC<=PC+sext(imm8)−1. The −1 compensates for the increment already applied in FETCH.
  - LOAD, STORE, ADD, SUB, MOVI and JMPZ_JUMP all go to FETCH next.
- PC arithmetic is modulo 2^PC_W: both PC+1 and the jump wrap silently.
- Every output not listed for the current state is 0. Outputs are Moore-decoded from state and IR (registered state, combinational decode).
- Reset (asynchronous, `rst`=0): state=FETCH, PC=0, IR=0, all strobes and enables 0. Reset asserted mid-instruction aborts the instruction with no partial write; on release, execution restarts from PC=0.

## Timing
- Latency is 3 cycles per instruction; a taken JMPZ takes 4.
- The first `i_rd` occurs in the first rising-edge cycle after `rst` deasserts; `i_addr`=0 in that cycle.
- The register-file write and the memory write both commit on the rising edge that ends the execute state.
- LOAD depends on `dm_r_data` being valid combinationally in the same cycle as `d_addr`/`d_rd`.
- `rf_rp_zero` is sampled at the end of the JMPZ state.

## Structure
- Shared package `spu_pkg` holds:
  - opcode constants (OP_LOAD…OP_JMPZ)
  - FSM state encoding
  - mux-select constants (RF_SEL_ALU/DM/IMM)
  - ALU-select constants (ALU_PASS/ADD/SUB)
- `spu_datapath` imports the same constants.
- One sub-module, `spu_pc`: the PC register with clear, increment and add-offset controls.

## Test plan
- Reset held, then released with `i_data`=0x3105 (MOVI R1,5):
  - `i_addr`=0 in FETCH.
  - In MOVI: rf_w_addr=1, rf_w_data=0x05, rf_s=10, rf_w_wr=1.
  - Next FETCH has `i_addr`=1.
- ADD 0x2312, then SUB 0x4312:
  - ADD: rf_rp_addr=1, rf_rq_addr=2, alu_s=01, rf_w_addr=3.
  - SUB: identical except alu_s=10.
  - Each instruction takes exactly 3 cycles.
- LOAD 0x0A40 and STORE 0x1A41:
  - LOAD: d_addr=0x40, d_rd=1, rf_s=01, rf_w_addr=10.
  - STORE: d_addr=0x41, d_wr=1, rf_rp_addr=10, rf_w_wr=0.
- JMPZ 0x52FE at PC=6:
  - With rf_rp_zero=1: next fetch is at `i_addr`=4 (4 cycles).
  - With rf_rp_zero=0: next fetch is at 7 (3 cycles).
- JMPZ at PC=0 with imm8=0xFF, taken: PC wraps to 0xFFFF.
- Opcode 0xF000 fetched: no strobes asserted in any cycle, next fetch at PC+1.
- `rst` pulsed low during ADD: rf_w_wr drops to 0 immediately, PC=0, state=FETCH.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared SPU encodings: opcodes, controller states and datapath select codes.
// The controller and spu_datapath both import this package so the encodings stay consistent.
package spu_pkg;

   localparam logic [3:0] OP_LOAD  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_MOVI  = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_JMPZ  = 4'd5;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_LOAD      = 4'd2,
      ST_STORE     = 4'd3,
      ST_ADD       = 4'd4,
      ST_MOVI      = 4'd5,
      ST_SUB       = 4'd6,
      ST_JMPZ      = 4'd7,
      ST_JMPZ_JUMP = 4'd8
   } state_t;

   localparam logic [1:0] RF_SEL_ALU = 2'b00;
   localparam logic [1:0] RF_SEL_DM  = 2'b01;
   localparam logic [1:0] RF_SEL_IMM = 2'b10;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;

   // Opcodes without an execute state fall straight back to FETCH.
   function automatic state_t op_to_state(input logic [3:0] op);
      case (op)
         OP_LOAD:  return ST_LOAD;
         OP_STORE: return ST_STORE;
         OP_ADD:   return ST_ADD;
         OP_MOVI:  return ST_MOVI;
         OP_SUB:   return ST_SUB;
         OP_JMPZ:  return ST_JMPZ;
         default:  return ST_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/spu_pc.sv
// SPU program counter: clear, increment by one, or add a signed offset.
// All arithmetic wraps modulo 2^PC_W.
module spu_pc #(
   parameter int PC_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_clr,
   input  logic            i_inc,
   input  logic            i_add,
   input  logic [PC_W-1:0] i_offset,
   output logic [PC_W-1:0] o_pc
);

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   logic [PC_W-1:0] r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= '0;
      end else if (i_clr) begin
         r_pc <= '0;
      end else if (i_add) begin
         r_pc <= r_pc + i_offset;
      end else if (i_inc) begin
         r_pc <= r_pc + PC_ONE;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/spu_controller.sv
// SPU control unit: fetch/decode/execute FSM owning PC and IR, driving all datapath controls.
// Control outputs are decoded combinationally from the registered state and IR.
module spu_controller
   import spu_pkg::*;
#(
   parameter int PC_W = 16,
   parameter int D_AW = 8
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] i_addr,
   output logic            i_rd,
   input  logic [15:0]     i_data,
   output logic [D_AW-1:0] d_addr,
   output logic            d_rd,
   output logic            d_wr,
   output logic            rf_s1,
   output logic            rf_s0,
   output logic [3:0]      rf_w_addr,
   output logic            rf_w_wr,
   output logic [3:0]      rf_rp_addr,
   output logic            rf_rp_rd,
   output logic [3:0]      rf_rq_addr,
   output logic            rf_rq_rd,
   output logic [7:0]      rf_w_data,
   output logic            alu_s1,
   output logic            alu_s0,
   input  logic            rf_rp_zero
);

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_t          r_state;
   logic [15:0]     r_ir;
   logic [PC_W-1:0] w_pc;
   logic            w_pc_clr;
   logic            w_pc_inc;
   logic            w_pc_add;
   logic [PC_W-1:0] w_jump_ofs;

   logic [3:0] w_op;
   logic [3:0] w_ra;
   logic [3:0] w_rb;
   logic [3:0] w_rc;
   logic [7:0] w_imm8;

   assign w_op   = r_ir[15:12];
   assign w_ra   = r_ir[11:8];
   assign w_rb   = r_ir[7:4];
   assign w_rc   = r_ir[3:0];
   assign w_imm8 = r_ir[7:0];

   // PC already points past the JMPZ, so the offset carries a -1 to land on JMPZ+sext(imm8).
   assign w_jump_ofs = {{(PC_W-8){w_imm8[7]}}, w_imm8} - PC_ONE;
   assign w_pc_inc   = (r_state == ST_FETCH);
   assign w_pc_add   = (r_state == ST_JMPZ_JUMP);

   spu_pc #(
      .PC_W (PC_W)
   ) u_pc (
      .clk      (clk),
      .rst_n    (rst),
      .i_clr    (w_pc_clr),
      .i_inc    (w_pc_inc),
      .i_add    (w_pc_add),
      .i_offset (w_jump_ofs),
      .o_pc     (w_pc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_FETCH;
         r_ir    <= '0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               r_ir    <= i_data;
               r_state <= ST_DECODE;
            end
            ST_DECODE: r_state <= op_to_state(w_op);
            ST_JMPZ:   r_state <= rf_rp_zero ? ST_JMPZ_JUMP : ST_FETCH;
            default:   r_state <= ST_FETCH;
         endcase
      end
   end

   always_comb begin
      i_rd       = 1'b0;
      d_addr     = '0;
      d_rd       = 1'b0;
      d_wr       = 1'b0;
      {rf_s1, rf_s0}   = RF_SEL_ALU;
      rf_w_addr  = '0;
      rf_w_wr    = 1'b0;
      rf_rp_addr = '0;
      rf_rp_rd   = 1'b0;
      rf_rq_addr = '0;
      rf_rq_rd   = 1'b0;
      rf_w_data  = '0;
      {alu_s1, alu_s0} = ALU_PASS;
      w_pc_clr   = 1'b0;
      case (r_state)
         ST_FETCH: i_rd = rst;  // held low while reset is asserted
         ST_DECODE, ST_JMPZ_JUMP: ;
         ST_LOAD: begin
            d_addr    = w_imm8[D_AW-1:0];
            d_rd      = 1'b1;
            {rf_s1, rf_s0} = RF_SEL_DM;
            rf_w_addr = w_ra;
            rf_w_wr   = 1'b1;
         end
         ST_STORE: begin
            d_addr     = w_imm8[D_AW-1:0];
            d_wr       = 1'b1;
            rf_rp_addr = w_ra;
            rf_rp_rd   = 1'b1;
         end
         ST_ADD, ST_SUB: begin
            rf_rp_addr = w_rb;
            rf_rp_rd   = 1'b1;
            rf_rq_addr = w_rc;
            rf_rq_rd   = 1'b1;
            {alu_s1, alu_s0} = (r_state == ST_ADD) ? ALU_ADD : ALU_SUB;
            {rf_s1, rf_s0}   = RF_SEL_ALU;
            rf_w_addr  = w_ra;
            rf_w_wr    = 1'b1;
         end
         ST_MOVI: begin
            rf_w_data = w_imm8;
            {rf_s1, rf_s0} = RF_SEL_IMM;
            rf_w_addr = w_ra;
            rf_w_wr   = 1'b1;
         end
         ST_JMPZ: begin
            rf_rp_addr = w_ra;
            rf_rp_rd   = 1'b1;
         end
         default: w_pc_clr = 1'b1;  // unreachable encoding: restart from address 0
      endcase
   end

   assign i_addr = w_pc;

endmodule

// File: tb/tb_spu_controller.sv
// Cycle-exact bench for spu_controller: an ISA-level model pushes the expected control
// vector of every cycle into a scoreboard queue, each scenario task drains and compares it.
module tb_spu_controller;

   typedef struct packed {
      logic [15:0] i_addr;
      logic        i_rd;
      logic [7:0]  d_addr;
      logic        d_rd;
      logic        d_wr;
      logic [1:0]  rf_s;
      logic [3:0]  rf_w_addr;
      logic        rf_w_wr;
      logic [3:0]  rp_addr;
      logic        rp_rd;
      logic [3:0]  rq_addr;
      logic        rq_rd;
      logic [7:0]  w_data;
      logic [1:0]  alu_s;
   } ctl_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] i_addr;
   logic        i_rd;
   logic [15:0] i_data;
   logic [7:0]  d_addr;
   logic        d_rd, d_wr, rf_s1, rf_s0, rf_w_wr, rf_rp_rd, rf_rq_rd, alu_s1, alu_s0;
   logic [3:0]  rf_w_addr, rf_rp_addr, rf_rq_addr;
   logic [7:0]  rf_w_data;
   logic        rf_rp_zero = 1'b0;

   logic [15:0] imem [0:65535];
   ctl_t        obs;
   ctl_t        sb [$];
   string       nm [$];
   int          n_run  = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   assign i_data = imem[i_addr];
   assign obs = {i_addr, i_rd, d_addr, d_rd, d_wr, rf_s1, rf_s0, rf_w_addr, rf_w_wr,
                 rf_rp_addr, rf_rp_rd, rf_rq_addr, rf_rq_rd, rf_w_data, alu_s1, alu_s0};

   spu_controller #(.PC_W(16), .D_AW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_addr     (i_addr),
      .i_rd       (i_rd),
      .i_data     (i_data),
      .d_addr     (d_addr),
      .d_rd       (d_rd),
      .d_wr       (d_wr),
      .rf_s1      (rf_s1),
      .rf_s0      (rf_s0),
      .rf_w_addr  (rf_w_addr),
      .rf_w_wr    (rf_w_wr),
      .rf_rp_addr (rf_rp_addr),
      .rf_rp_rd   (rf_rp_rd),
      .rf_rq_addr (rf_rq_addr),
      .rf_rq_rd   (rf_rq_rd),
      .rf_w_data  (rf_w_data),
      .alu_s1     (alu_s1),
      .alu_s0     (alu_s0),
      .rf_rp_zero (rf_rp_zero)
   );

   // ---------------- reference model of the control vector ----------------
   function automatic ctl_t exp_idle(input logic [15:0] pc);
      ctl_t c = '0;
      c.i_addr = pc;
      return c;
   endfunction

   function automatic ctl_t exp_fetch(input logic [15:0] pc);
      ctl_t c = exp_idle(pc);
      c.i_rd = 1'b1;
      return c;
   endfunction

   function automatic ctl_t exp_exec(input logic [15:0] ir, input logic [15:0] pc);
      ctl_t c = exp_idle(pc);
      case (ir[15:12])
         4'd0: begin c.d_addr = ir[7:0]; c.d_rd = 1; c.rf_s = 2'b01; c.rf_w_addr = ir[11:8]; c.rf_w_wr = 1; end
         4'd1: begin c.d_addr = ir[7:0]; c.d_wr = 1; c.rp_addr = ir[11:8]; c.rp_rd = 1; end
         4'd2, 4'd4: begin
            c.rp_addr = ir[7:4]; c.rp_rd = 1; c.rq_addr = ir[3:0]; c.rq_rd = 1;
            c.alu_s = (ir[15:12] == 4'd2) ? 2'b01 : 2'b10;
            c.rf_s = 2'b00; c.rf_w_addr = ir[11:8]; c.rf_w_wr = 1;
         end
         4'd3: begin c.w_data = ir[7:0]; c.rf_s = 2'b10; c.rf_w_addr = ir[11:8]; c.rf_w_wr = 1; end
         4'd5: begin c.rp_addr = ir[11:8]; c.rp_rd = 1; end
         default: ;
      endcase
      return c;
   endfunction

   task automatic push_x(input ctl_t c, input string t);
      sb.push_back(c);
      nm.push_back(t);
   endtask

   // Walk n instructions from start_pc, pushing each cycle's expected vector, then the next fetch.
   task automatic push_run(input string tag, input logic [15:0] start_pc, input int n, input logic zero);
      logic [15:0] pc = start_pc;
      logic [15:0] ir;
      logic [15:0] jpc;
      for (int k = 0; k < n; k++) begin
         ir  = imem[pc];
         jpc = pc;
         push_x(exp_fetch(pc), $sformatf("%s.i%0d.fetch", tag, k));
         pc = pc + 16'd1;
         push_x(exp_idle(pc), $sformatf("%s.i%0d.decode", tag, k));
         if (ir[15:12] <= 4'd5)
            push_x(exp_exec(ir, pc), $sformatf("%s.i%0d.exec", tag, k));
         if (ir[15:12] == 4'd5 && zero) begin
            push_x(exp_idle(pc), $sformatf("%s.i%0d.jump", tag, k));
            pc = jpc + {{8{ir[7]}}, ir[7:0]};
         end
      end
      push_x(exp_fetch(pc), $sformatf("%s.next.fetch", tag));
   endtask

   task automatic clear_prog();
      for (int a = 0; a < 16; a++) imem[a] = 16'hF000;
      imem[16'hFFFF] = 16'hF000;
   endtask

   // Assert reset for two cycles and release it on a falling edge.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      clear_prog();
      imem[0] = 16'h3105;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         n_run++;
         if (obs !== ctl_t'('0)) begin
            n_fail++;
            $display("FAIL reset.hold%0d got=%h exp=%h", k, obs, ctl_t'('0));
         end else $display("[TB] ok reset.hold%0d %h", k, obs);
         @(negedge clk);
      end
      rst = 1'b1;
      push_run("movi", 16'd0, 1, 1'b0);
      while (sb.size() != 0) begin
         ctl_t e = sb.pop_front();
         string t = nm.pop_front();
         #1;
         n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL %s got=%h exp=%h", t, obs, e); end
         else $display("[TB] ok %s %h", t, obs);
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      clear_prog();
      imem[0] = 16'h2312;
      imem[1] = 16'h4312;
      do_reset();
      push_run("addsub", 16'd0, 2, 1'b0);
      while (sb.size() != 0) begin
         ctl_t e = sb.pop_front();
         string t = nm.pop_front();
         #1;
         n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL %s got=%h exp=%h", t, obs, e); end
         else $display("[TB] ok %s %h", t, obs);
         @(negedge clk);
      end
   endtask

   task automatic test_load_store();
      clear_prog();
      imem[0] = 16'h0A40;
      imem[1] = 16'h1A41;
      do_reset();
      push_run("ldst", 16'd0, 2, 1'b0);
      while (sb.size() != 0) begin
         ctl_t e = sb.pop_front();
         string t = nm.pop_front();
         #1;
         n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL %s got=%h exp=%h", t, obs, e); end
         else $display("[TB] ok %s %h", t, obs);
         @(negedge clk);
      end
   endtask

   task automatic test_jmpz(input logic zero);
      clear_prog();
      imem[6] = 16'h52FE;
      rf_rp_zero = zero;
      do_reset();
      push_run(zero ? "jmpz_taken" : "jmpz_not", 16'd0, 7, zero);
      while (sb.size() != 0) begin
         ctl_t e = sb.pop_front();
         string t = nm.pop_front();
         #1;
         n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL %s got=%h exp=%h", t, obs, e); end
         else $display("[TB] ok %s %h", t, obs);
         @(negedge clk);
      end
      rf_rp_zero = 1'b0;
   endtask

   task automatic test_jmpz_wrap();
      clear_prog();
      imem[0] = 16'h52FF;
      rf_rp_zero = 1'b1;
      do_reset();
      push_run("wrap", 16'd0, 1, 1'b1);
      while (sb.size() != 0) begin
         ctl_t e = sb.pop_front();
         string t = nm.pop_front();
         #1;
         n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL %s got=%h exp=%h", t, obs, e); end
         else $display("[TB] ok %s %h", t, obs);
         @(negedge clk);
      end
      rf_rp_zero = 1'b0;
   endtask

   task automatic test_noop();
      clear_prog();
      imem[0] = 16'hF000;
      imem[1] = 16'h6ABC;
      do_reset();
      push_run("noop", 16'd0, 2, 1'b0);
      while (sb.size() != 0) begin
         ctl_t e = sb.pop_front();
         string t = nm.pop_front();
         #1;
         n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL %s got=%h exp=%h", t, obs, e); end
         else $display("[TB] ok %s %h", t, obs);
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_add();
      clear_prog();
      imem[0] = 16'h2312;
      do_reset();
      push_x(exp_fetch(16'd0), "abort.fetch");
      push_x(exp_idle(16'd1), "abort.decode");
      push_x(exp_exec(16'h2312, 16'd1), "abort.add");
      while (sb.size() != 0) begin
         ctl_t e = sb.pop_front();
         string t = nm.pop_front();
         #1;
         n_run++;
         if (obs !== e) begin n_fail++; $display("FAIL %s got=%h exp=%h", t, obs, e); end
         else $display("[TB] ok %s %h", t, obs);
         if (sb.size() != 0) @(negedge clk);
      end
      // still inside the ADD cycle: pull reset asynchronously, away from any clock edge
      #1;
      rst = 1'b0;
      #1;
      n_run++;
      if (obs !== ctl_t'('0)) begin
         n_fail++;
         $display("FAIL abort.in_reset got=%h exp=%h", obs, ctl_t'('0));
      end else $display("[TB] ok abort.in_reset %h", obs);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_run++;
      if (obs !== exp_fetch(16'd0)) begin
         n_fail++;
         $display("FAIL abort.refetch got=%h exp=%h", obs, exp_fetch(16'd0));
      end else $display("[TB] ok abort.refetch %h", obs);
      @(negedge clk);
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) imem[a] = 16'hF000;
      test_reset();
      test_back_to_back();
      test_load_store();
      test_jmpz(1'b1);
      test_jmpz(1'b0);
      test_jmpz_wrap();
      test_noop();
      test_reset_mid_add();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
